// File: rtl/risky_pkg.sv
// rtl/risky_pkg.sv - shared constants and types for the risky core
package risky_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low two bits are forced to zero.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {inst, pc} entries
module fetch_fifo
  import risky_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  fetch_entry_t  i_entry,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_entry,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // A pop on an empty queue is ignored; a push into a full queue only lands alongside a pop.
  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && ((count_q != CW'(DEPTH)) || do_pop);

  // Next pointers and occupancy; flush empties the queue regardless of push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; unreset because the count gates every read.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_entry;
  end

  assign o_entry = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end with credit-limited requests and redirect
module fetch_stage
  import risky_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_valid,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            resp_ok;
  logic            keep;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Every slot is either in flight at the memory or parked in the FIFO, so the FIFO can never overflow.
  assign credit_used  = {1'b0, outst_q} + {1'b0, fifo_count};
  assign o_imem_valid = !i_rst && !i_redirect && (credit_used < (CW+1)'(DEPTH));
  assign o_imem_addr  = pc_q;
  assign req_fire     = o_imem_valid && i_imem_ready;

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign resp_ok    = i_imem_rvalid && (outst_q != '0);
  assign keep       = resp_ok && (drop_q == '0) && !i_redirect;
  assign push_entry = '{inst: i_imem_rdata, pc: resp_pc_q};

  assign o_inst_valid = (fifo_count != '0);
  assign pop          = o_inst_valid && i_inst_ready;
  assign o_inst       = o_inst_valid ? head.inst : NOP_INST;
  assign o_pc         = o_inst_valid ? head.pc : RESET_PC;

  // Next-state for PCs and counters; redirect overrides and arms the drop counter with whatever is still in flight.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(resp_ok);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (keep) resp_pc_d = resp_pc_q + 32'd4;
    if (resp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (i_redirect) begin
      pc_d      = word_align(i_redirect_pc);
      resp_pc_d = word_align(i_redirect_pc);
      drop_d    = outst_d;
    end
  end

  // Fetch state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (keep),
    .i_entry (push_entry),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .o_entry (head),
    .o_count (fifo_count)
  );

  a_no_orphan_resp: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rvalid && (outst_q == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  typedef struct {
    logic        ir;
    logic        mr;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b1;

  logic        a_rvalid = 1'b0;
  logic [31:0] a_rdata = 32'h0;
  logic        a_imem_valid, a_inst_valid;
  logic [31:0] a_imem_addr, a_inst, a_pc;

  logic        b_rvalid = 1'b0;
  logic [31:0] b_rdata = 32'h0;
  logic        b_imem_valid, b_inst_valid;
  logic [31:0] b_imem_addr, b_inst, b_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  req_t mq_a[$];
  req_t mq_b[$];
  rec_t log_a[$];
  rec_t log_b[$];
  vec_t vt[20];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .o_imem_valid(a_imem_valid), .o_imem_addr(a_imem_addr), .i_imem_ready(imem_ready),
    .i_imem_rvalid(a_rvalid), .i_imem_rdata(a_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_inst_valid(a_inst_valid), .i_inst_ready(inst_ready), .o_inst(a_inst), .o_pc(a_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .o_imem_valid(b_imem_valid), .o_imem_addr(b_imem_addr), .i_imem_ready(imem_ready),
    .i_imem_rvalid(b_rvalid), .i_imem_rdata(b_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_inst_valid(b_inst_valid), .i_inst_ready(inst_ready), .o_inst(b_inst), .o_pc(b_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Book-keeping for both memory models and decode logs, then advance to the next negedge.
  task automatic tick();
    if (rst) begin
      mq_a.delete(); mq_b.delete(); log_a.delete(); log_b.delete();
    end else begin
      if (a_rvalid) void'(mq_a.pop_front());
      if (b_rvalid) void'(mq_b.pop_front());
      if (a_imem_valid && imem_ready) mq_a.push_back('{addr: a_imem_addr, due: cyc + lat});
      if (b_imem_valid && imem_ready) mq_b.push_back('{addr: b_imem_addr, due: cyc + 1});
      if (a_inst_valid && inst_ready) log_a.push_back('{inst: a_inst, pc: a_pc});
      if (b_inst_valid && inst_ready) log_b.push_back('{inst: b_inst, pc: b_pc});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    a_rvalid = 1'b0;
    a_rdata  = 32'hDEAD_BEEF;
    if (mq_a.size() > 0) begin
      if (mq_a[0].due <= cyc) begin
        a_rvalid = 1'b1;
        a_rdata  = mem_word(mq_a[0].addr);
      end
    end
    b_rvalid = 1'b0;
    b_rdata  = 32'hDEAD_BEEF;
    if (mq_b.size() > 0) begin
      if (mq_b[0].due <= cyc) begin
        b_rvalid = 1'b1;
        b_rdata  = mem_word(mq_b[0].addr);
      end
    end
  endtask

  task automatic step();
    #1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_ready = 1'b1;
    imem_ready = 1'b1;
    redirect = 1'b0;
    step();
    step();
    #1;
    chk("rst_a_imem_valid", 32'(a_imem_valid), 32'd0);
    chk("rst_a_inst_valid", 32'(a_inst_valid), 32'd0);
    chk("rst_a_inst", a_inst, 32'h0000_0013);
    chk("rst_a_pc", a_pc, 32'h0000_0000);
    chk("rst_b_imem_valid", 32'(b_imem_valid), 32'd0);
    chk("rst_b_inst_valid", 32'(b_inst_valid), 32'd0);
    chk("rst_b_pc", b_pc, 32'hFFFF_FFF8);
    rst = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [31:0] start, input int min_n);
    checks++;
    if (log_a.size() < min_n) begin
      errors++;
      $display("FAIL %s_count: got %0d pops expected at least %0d", tag, log_a.size(), min_n);
    end
    foreach (log_a[i]) begin
      chk({tag, "_pc"}, log_a[i].pc, start + 32'(4 * i));
      chk({tag, "_inst"}, log_a[i].inst, mem_word(start + 32'(4 * i)));
    end
  endtask

  initial begin
    logic [31:0] exp_wrap [4];

    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h00};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    vt[11] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14};
    vt[13] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14};
    vt[14] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14};
    vt[15] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    vt[16] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    vt[17] = '{1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};
    vt[18] = '{1'b1, 1'b1, 1'b1, 32'h30, 1'b1, 32'h24};
    vt[19] = '{1'b1, 1'b1, 1'b1, 32'h34, 1'b1, 32'h28};

    @(negedge clk);

    // Streaming with 1-cycle memory, a memory stall and a decode stall.
    lat = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      inst_ready = vt[i].ir;
      imem_ready = vt[i].mr;
      #1;
      chk($sformatf("v%0d_imem_valid", i), 32'(a_imem_valid), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("v%0d_imem_addr", i), a_imem_addr, vt[i].ea);
      chk($sformatf("v%0d_inst_valid", i), 32'(a_inst_valid), 32'(vt[i].eiv));
      if (vt[i].eiv) begin
        chk($sformatf("v%0d_pc", i), a_pc, vt[i].epc);
        chk($sformatf("v%0d_inst", i), a_inst, mem_word(vt[i].epc));
      end
      tick();
    end

    // Redirect with two requests in flight at 3-cycle latency.
    lat = 3;
    do_reset();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir1_no_req", 32'(a_imem_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir1_req_valid", 32'(a_imem_valid), 32'd1);
    chk("redir1_req_addr", a_imem_addr, 32'h0000_0100);
    chk("redir1_fifo_empty", 32'(a_inst_valid), 32'd0);
    tick();
    for (int i = 0; i < 16; i++) step();
    check_log("redir1", 32'h0000_0100, 4);

    // Second redirect while the first one is still dropping two stale words.
    lat = 4;
    do_reset();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    #1;
    chk("redir2a_req_addr", a_imem_addr, 32'h0000_0100);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    #1;
    chk("redir2b_req_valid", 32'(a_imem_valid), 32'd1);
    chk("redir2b_req_addr", a_imem_addr, 32'h0000_0200);
    chk("redir2b_fifo_empty", 32'(a_inst_valid), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) step();
    check_log("redir2", 32'h0000_0200, 4);

    // Mid-operation reset, then PC wrap from RESET_PC = 0xFFFF_FFF8.
    lat = 1;
    do_reset();
    #1;
    chk("post_rst_req_addr_b", b_imem_addr, 32'hFFFF_FFF8);
    chk("post_rst_req_valid_a", 32'(a_imem_valid), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) step();
    exp_wrap[0] = 32'hFFFF_FFF8;
    exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000;
    exp_wrap[3] = 32'h0000_0004;
    checks++;
    if (log_b.size() < 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d pops expected at least 4", log_b.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wrap%0d_pc", i), log_b[i].pc, exp_wrap[i]);
        chk($sformatf("wrap%0d_inst", i), log_b[i].inst, mem_word(exp_wrap[i]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
